seq_restore_divider: RTL

Multi-cycle integer divider that retires `K` quotient bits per clock using restoring division on an `N+1`-bit partial remainder. It accepts one operand pair per start/ready handshake and supports unsigned and two's-complement signed modes. Divide-by-zero and signed overflow are fully defined. It is the sequential, parametrised successor to the team's single-cycle combinational divider and sits behind the datapath ALU as its long-latency divide unit.

---
 rtl/seq_div_pkg.sv | 22 ++
 rtl/div_step.sv | 34 +++
 rtl/seq_restore_divider.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and elaboration helpers for the sequential
// restoring divider (FSM state encoding, legal-K check, counter width).
package seq_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_PREP = 2'd1,
    DIV_ITER = 2'd2,
    DIV_FIX  = 2'd3
  } div_state_e;

  // Width of the iteration counter, which must hold N/K.
  function automatic int iter_cnt_w(input int n, input int k);
    return $clog2(n / k + 1);
  endfunction

  // Quotient bits per cycle must be 1, 2 or 4 and divide the operand width.
  function automatic bit k_is_legal(input int n, input int k);
    return (n >= 4) && ((k == 1) || (k == 2) || (k == 4)) && ((n % k) == 0);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one iteration of restoring division retiring K quotient bits.
// Purely combinational; K single-bit steps cascaded within one cycle.
module div_step #(
  parameter int N = 64,
  parameter int K = 1
) (
  input  logic [N:0]   p_in,
  input  logic [N-1:0] sr_in,
  input  logic [N-1:0] dmag,
  output logic [N:0]   p_out,
  output logic [N-1:0] sr_out,
  output logic [K-1:0] q_bits
);

  logic [N:0] p_sh;
  logic [N:0] diff;

  // Shift in the next dividend bit, trial-subtract, restore on borrow (bit N).
  always_comb begin
    p_out  = p_in;
    sr_out = sr_in;
    q_bits = '0;
    p_sh   = '0;
    diff   = '0;
    for (int i = 0; i < K; i++) begin
      p_sh   = (p_out << 1) | (N+1)'(sr_out[N-1]);
      sr_out = sr_out << 1;
      diff   = p_sh - {1'b0, dmag};
      q_bits[K-1-i] = ~diff[N];
      p_out  = diff[N] ? p_sh : diff;
    end
  end

endmodule

// File: rtl/seq_restore_divider.sv
// seq_restore_divider: multi-cycle restoring divider, K quotient bits/clock.
// Build option SEQ_DIV_SIGNED_EN: when defined, signed_mode selects
// two's-complement operation; when undefined, signed_mode is ignored and
// every operation is unsigned with identical latency.
//
// state    | meaning
// DIV_IDLE | ready=1, waiting for start
// DIV_PREP | operand magnitudes, divide-by-zero detect, load counter
// DIV_ITER | K restoring steps per cycle until the counter expires
// DIV_FIX  | sign fix-up, register results, pulse done
module seq_restore_divider
  import seq_div_pkg::*;
#(
  parameter int N = 64,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         ready,
  input  logic         signed_mode,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW    = iter_cnt_w(N, K);
  localparam int ITERS = N / K;

  if (!k_is_legal(N, K)) begin : g_bad_param
    $error("seq_restore_divider: K must be 1, 2 or 4, divide N, and N >= 4");
  end

  div_state_e    state;
  logic [CW-1:0] cnt;
  logic [N:0]    p;
  logic [N-1:0]  sr;       // dividend magnitude, refilled with quotient bits
  logic [N-1:0]  dmag;
  logic          dz_pend;

  logic [N:0]    p_step;
  logic [N-1:0]  sr_step;
  logic [K-1:0]  q_step;

`ifdef SEQ_DIV_SIGNED_EN
  logic sm;
  logic q_neg;
  logic r_neg;

  function automatic logic [N-1:0] mag(input logic [N-1:0] v);
    return v[N-1] ? -v : v;
  endfunction
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
`endif

  assign ready = (state == DIV_IDLE);

  div_step #(.N(N), .K(K)) u_step (
    .p_in   (p),
    .sr_in  (sr),
    .dmag   (dmag),
    .p_out  (p_step),
    .sr_out (sr_step),
    .q_bits (q_step)
  );

  // Sequencer plus operand, partial-remainder and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= DIV_IDLE;
      cnt         <= '0;
      p           <= '0;
      sr          <= '0;
      dmag        <= '0;
      dz_pend     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      sm          <= 1'b0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (start) begin
            sr    <= dividend;
            dmag  <= divisor;
`ifdef SEQ_DIV_SIGNED_EN
            sm    <= signed_mode;
`endif
            state <= DIV_PREP;
          end
        end
        DIV_PREP: begin
          p <= '0;
          if (dmag == '0) begin
            // Leave sr untouched so the raw dividend becomes the remainder.
            dz_pend <= 1'b1;
            state   <= DIV_FIX;
          end else begin
            dz_pend <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            if (sm) begin
              sr    <= mag(sr);
              dmag  <= mag(dmag);
              q_neg <= sr[N-1] ^ dmag[N-1];
              r_neg <= sr[N-1];
            end else begin
              q_neg <= 1'b0;
              r_neg <= 1'b0;
            end
`endif
            cnt   <= CW'(ITERS);
            state <= DIV_ITER;
          end
        end
        DIV_ITER: begin
          p   <= p_step;
          sr  <= sr_step | N'(q_step);
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          if (dz_pend) begin
            quotient    <= '1;
            remainder   <= sr;
            div_by_zero <= 1'b1;
          end else begin
`ifdef SEQ_DIV_SIGNED_EN
            quotient    <= q_neg ? -sr : sr;
            remainder   <= r_neg ? -p[N-1:0] : p[N-1:0];
`else
            quotient    <= sr;
            remainder   <= p[N-1:0];
`endif
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule
